// File: rtl/nn_wb_stream_bridge.sv
// rtl/nn_wb_stream_bridge.sv - Wishbone slave bridging host TX FIFOs and RX capture registers to the trainable_nn core
module nn_wb_stream_bridge #(
  parameter int          N_CH      = 2,
  parameter int          DEPTH     = 4,
  parameter int          DW        = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [N_CH-1:0]    tx_valid_o,
  output logic [N_CH*DW-1:0] tx_data_o,
  input  logic [N_CH-1:0]    tx_ready_i,
  input  logic [N_CH-1:0]    rx_valid_i,
  input  logic [N_CH*DW-1:0] rx_data_i,
  output logic [N_CH-1:0]    rx_ready_o,
  output logic [2:0]         irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0]   mem [N_CH][DEPTH];
  logic [PW-1:0]   wr_ptr [N_CH];
  logic [PW-1:0]   rd_ptr [N_CH];
  logic [PW-1:0]   level [N_CH];
  logic [DW-1:0]   hold [N_CH];
  logic [N_CH-1:0] hold_valid, ovf, unf, ie_rx, ie_tx, full, empty;
  logic [N_CH-1:0] push_req, do_push, pop, rd_req, st_wr;
  logic [31:0]     rdata;

  logic       hit, is_ch, is_ie;
  logic [7:0] off;
  logic [2:0] sel_ch;
  logic [1:0] reg_idx;
  logic       unused_ok;

  assign off     = wbs_adr_i[7:0];
  assign sel_ch  = off[6:4];
  assign reg_idx = off[3:2];
  assign hit     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign is_ch   = ~off[7] & ({29'd0, sel_ch} < N_CH);
  assign is_ie   = (off == 8'h80);
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, BASE_ADDR[7:0]};

  always_comb begin
    tx_data_o = '0;
    rdata     = '0;
    push_req  = '0;
    do_push   = '0;
    pop       = '0;
    rd_req    = '0;
    st_wr     = '0;
    for (int c = 0; c < N_CH; c++) begin
      level[c]   = wr_ptr[c] - rd_ptr[c];
      full[c]    = (level[c] == PW'(DEPTH));
      empty[c]   = (wr_ptr[c] == rd_ptr[c]);
      pop[c]     = ~empty[c] & tx_ready_i[c];
      tx_data_o[c*DW +: DW] = empty[c] ? '0 : mem[c][rd_ptr[c][AW-1:0]];
      if (hit && is_ch && sel_ch == 3'(c)) begin
        push_req[c] = wbs_we_i & (reg_idx == 2'd0) & (|wbs_sel_i);
        rd_req[c]   = ~wbs_we_i & (reg_idx == 2'd1);
        st_wr[c]    = wbs_we_i & (reg_idx == 2'd2);
        case (reg_idx)
          2'd1: rdata[DW-1:0] = hold_valid[c] ? hold[c] : '0;
          2'd2: rdata = {19'd0, unf[c], ovf[c], hold_valid[c], empty[c], full[c], 8'(level[c])};
          default: ;
        endcase
      end
      // Push acceptance is judged on the registered full flag, even if a pop lands on the same edge.
      do_push[c] = push_req[c] & ~full[c];
    end
    if (is_ie) begin
      rdata[N_CH-1:0] = ie_rx;
      rdata[8 +: N_CH] = ie_tx;
    end
  end

  assign tx_valid_o = ~empty;
  assign rx_ready_o = ~hold_valid;
  assign irq_o[0]   = |(hold_valid & ie_rx);
  assign irq_o[1]   = |(empty & ie_tx);
  assign irq_o[2]   = |(ovf | unf);

  always_ff @(posedge wb_clk_i) begin
    for (int c = 0; c < N_CH; c++)
      if (do_push[c]) mem[c][wr_ptr[c][AW-1:0]] <= wbs_dat_i[DW-1:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      hold_valid <= '0;
      ovf        <= '0;
      unf        <= '0;
      ie_rx      <= '0;
      ie_tx      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        hold[c]   <= '0;
      end
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rdata : '0;
      if (hit && wbs_we_i && is_ie) begin
        ie_rx <= wbs_dat_i[N_CH-1:0];
        ie_tx <= wbs_dat_i[8 +: N_CH];
      end
      for (int c = 0; c < N_CH; c++) begin
        if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])     rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push_req[c] && full[c])           ovf[c] <= 1'b1;
        else if (st_wr[c] && wbs_dat_i[11])   ovf[c] <= 1'b0;
        if (rd_req[c]) begin
          if (hold_valid[c]) hold_valid[c] <= 1'b0;
          else               unf[c]        <= 1'b1;
        end else if (st_wr[c] && wbs_dat_i[12]) begin
          unf[c] <= 1'b0;
        end
        if (rx_valid_i[c] && !hold_valid[c]) begin
          hold[c]       <= rx_data_i[c*DW +: DW];
          hold_valid[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_wb_stream_bridge.sv
// tb/tb_nn_wb_stream_bridge.sv - directed scoreboard bench for nn_wb_stream_bridge
module tb_nn_wb_stream_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [1:0]  tx_valid, tx_ready = 2'b00, rx_valid = 2'b00, rx_ready;
  logic [31:0] tx_data, rx_data = '0;
  logic [2:0]  irq;

  int total = 0;
  int bad = 0;
  logic [31:0] rd_q[$];
  logic [15:0] tx_q[$];

  nn_wb_stream_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic acked);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    acked = 1'b0; r = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; r = rdat; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic acked;
    wb_cycle(1'b1, a, d, r, acked);
    check({tag, "_ack"}, {31'd0, acked}, 32'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic acked;
    rd_q.push_back(exp);
    wb_cycle(1'b0, a, 32'd0, r, acked);
    check({tag, "_ack"}, {31'd0, acked}, 32'd1);
    check(tag, r, rd_q.pop_front());
  endtask

  initial begin
    logic [31:0] r;
    logic acked;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_txv", {30'd0, tx_valid}, 32'd0);
    check("rst_txd", tx_data, 32'd0);
    check("rst_rxr", {30'd0, rx_ready}, 32'd3);
    check("rst_irq", {29'd0, irq}, 32'd0);
    rst = 1'b0;
    wb_read("rst_status", 32'h3000_0008, 32'h0000_0200);

    // Fill channel 0 with the core stalled.
    for (int i = 0; i < 4; i++) begin
      wb_write("push", 32'h3000_0000, 32'h00A1 + i);
      tx_q.push_back(16'h00A1 + 16'(i));
      if (i == 0) check("push_vis", {31'd0, tx_valid[0]}, 32'd1);
    end
    check("ack_one", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    check("ack_drop", {31'd0, ack}, 32'd0);
    wb_read("full_status", 32'h3000_0008, 32'h0000_0104);
    wb_write("push5", 32'h3000_0000, 32'h0000_00A5);
    wb_read("ovf_status", 32'h3000_0008, 32'h0000_0904);
    check("ovf_irq", {29'd0, irq}, 32'd4);
    wb_write("ovf_clr", 32'h3000_0008, 32'h0000_0800);
    check("ovf_clr_irq", {29'd0, irq}, 32'd0);

    @(posedge clk); #1;
    tx_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_v", {31'd0, tx_valid[0]}, 32'd1);
      check("drain_d", {16'd0, tx_data[15:0]}, {16'd0, tx_q.pop_front()});
      @(posedge clk); #1;
    end
    check("drain_end", {31'd0, tx_valid[0]}, 32'd0);
    tx_ready[0] = 1'b0;
    wb_write("ie_tx", 32'h3000_0080, 32'h0000_0100);
    check("irq_txe", {29'd0, irq}, 32'd2);

    // RX capture on channel 1.
    rx_valid[1] = 1'b1;
    rx_data[31:16] = 16'h5A5A;
    @(posedge clk); #1;
    rx_valid[1] = 1'b0;
    rx_data = '0;
    check("rx_ready_fall", {31'd0, rx_ready[1]}, 32'd0);
    wb_write("ie_rx", 32'h3000_0080, 32'h0000_0002);
    check("irq_rx", {29'd0, irq}, 32'd1);
    wb_read("ie_rd", 32'h3000_0080, 32'h0000_0002);
    wb_read("rx_rd", 32'h3000_0014, 32'h0000_5A5A);
    check("irq_rx_clr", {29'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("rx_ready_rise", {31'd0, rx_ready[1]}, 32'd1);
    wb_read("rx_rd_empty", 32'h3000_0014, 32'h0000_0000);
    wb_read("unf_status", 32'h3000_0018, 32'h0000_1200);
    check("unf_irq", {29'd0, irq[2]}, 32'd1);
    wb_write("unf_clr", 32'h3000_0018, 32'h0000_1000);
    check("unf_clr_irq", {29'd0, irq[2]}, 32'd0);
    wb_read("unf_cleared", 32'h3000_0018, 32'h0000_0200);
    wb_write("ie_off", 32'h3000_0080, 32'h0000_0000);

    // Full FIFO, push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      wb_write("refill", 32'h3000_0000, 32'h00B1 + i);
      tx_q.push_back(16'h00B1 + 16'(i));
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h0000_00B5;
    tx_ready[0] = 1'b1;
    @(posedge clk); #1;
    tx_ready[0] = 1'b0;
    check("simul_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    void'(tx_q.pop_front());
    check("simul_head", {16'd0, tx_data[15:0]}, {16'd0, tx_q[0]});
    wb_read("simul_status", 32'h3000_0008, 32'h0000_0803);
    @(posedge clk); #1;
    tx_ready[0] = 1'b1;
    @(posedge clk); #1;
    tx_ready[0] = 1'b0;
    void'(tx_q.pop_front());
    wb_write("ovf_clr2", 32'h3000_0008, 32'h0000_0800);
    wb_read("lvl2_status", 32'h3000_0008, 32'h0000_0002);
    check("lvl2_head", {16'd0, tx_data[15:0]}, {16'd0, tx_q[0]});

    // Decode boundaries.
    wb_cycle(1'b0, 32'h3000_0100, 32'd0, r, acked);
    check("miss_noack", {31'd0, acked}, 32'd0);
    wb_write("unmapped_wr", 32'h3000_0040, 32'hFFFF_FFFF);
    wb_read("unmapped_rd", 32'h3000_0040, 32'h0000_0000);
    wb_read("reserved_rd", 32'h3000_000C, 32'h0000_0000);

    // Reset while the ack is pending.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h0000_00C1;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_txv", {30'd0, tx_valid}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tx_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wb_read("post_rst_status", 32'h3000_0008, 32'h0000_0200);
    check("post_rst_rxr", {30'd0, rx_ready}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
